// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: hazard detection and forwarding control for the 5-stage CPU.
//
// Keeps a shadow copy of the destination/valid fields of the EX, MEM and WB
// stages. From that copy and the ID-stage decode it drives the pipeline
// enables, bubble/flush controls and operand-mux selects.
//
// Parameters:
//   REG_ADDR_W  register address width (register 0 is hard-wired zero)
//   LONG_LAT    EX occupancy of a long op in cycles, 1..15 (1 = no hold)
//   CNT_W       statistics counter width (HAZARD_STATS_EN builds only)
//
// Ports:
//   clk, arst_n           clock, asynchronous active-low reset
//   enable                0 freezes all internal state
//   id_*                  ID-stage decode of the instruction being issued
//   mem_redirect          taken branch/jump resolved in MEM
//   stall_pc, stall_ifid  hold PC / IF-ID register
//   bubble_idex           load zeros into ID/EX controls
//   hold_ex               hold ID/EX register (long op occupying EX)
//   bubble_exmem          zero EX/MEM controls
//   flush_ifid            clear IF/ID
//   fwd_rs_sel/rt_sel     EX operand mux: 0 regfile, 1 MEM alu_out, 2 WB wdata
//   id_byp_rs/rt          ID regfile read takes WB wdata
//   stall_cnt, flush_cnt  saturating event counters (HAZARD_STATS_EN only)
//
// Build option: define HAZARD_STATS_EN to add the statistics counters.

module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LONG_LAT   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_reg_write,
    input  logic [REG_ADDR_W-1:0] id_waddr,
    input  logic                  id_mem_read,
    input  logic                  id_long_op,
    input  logic                  mem_redirect,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
`endif
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  bubble_idex,
    output logic                  hold_ex,
    output logic                  bubble_exmem,
    output logic                  flush_ifid,
    output logic [1:0]            fwd_rs_sel,
    output logic [1:0]            fwd_rt_sel,
    output logic                  id_byp_rs,
    output logic                  id_byp_rt
);

    // Destination part of a stage shadow (MEM/WB need nothing else).
    typedef struct packed {
        logic                  valid;
        logic                  rw;
        logic [REG_ADDR_W-1:0] waddr;
    } dst_t;

    // EX additionally tracks its sources and whether it is a load.
    typedef struct packed {
        dst_t                  d;
        logic                  load;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  urs;
        logic                  urt;
    } ex_t;

    localparam logic [3:0] LC_INIT = 4'(LONG_LAT - 1);

    ex_t        ex_q, ex_d;
    dst_t       mem_q, mem_d, wb_q, wb_d;
    logic [3:0] lc_q, lc_d;
    logic       hold, load_use;

    function automatic logic hit(input dst_t s, input logic [REG_ADDR_W-1:0] a);
        return s.valid && s.rw && (s.waddr != '0) && (s.waddr == a);
    endfunction

    function automatic logic [1:0] fwd(input logic use_src, input logic [REG_ADDR_W-1:0] a,
                                       input dst_t m, input dst_t w);
        if (!use_src)   return 2'd0;
        if (hit(m, a))  return 2'd1;
        if (hit(w, a))  return 2'd2;
        return 2'd0;
    endfunction

    // lc_q is only ever non-zero while a long op sits in EX.
    assign hold     = (lc_q != 4'd0);
    assign load_use = id_valid && ex_q.d.valid && ex_q.load && (ex_q.d.waddr != '0) &&
                      ((id_uses_rs && id_rs == ex_q.d.waddr) ||
                       (id_uses_rt && id_rt == ex_q.d.waddr));

    // A redirect overrides every stall/hold; hold has priority over load-use.
    assign stall_pc     = !mem_redirect && (hold || load_use);
    assign stall_ifid   = stall_pc;
    assign hold_ex      = !mem_redirect && hold;
    assign bubble_idex  = mem_redirect || (!hold && load_use);
    // On a redirect the instruction in EX is on the wrong path as well, so it
    // is squashed on its way into MEM.
    assign bubble_exmem = mem_redirect || hold;
    assign flush_ifid   = mem_redirect;

    assign fwd_rs_sel = fwd(ex_q.d.valid && ex_q.urs, ex_q.rs, mem_q, wb_q);
    assign fwd_rt_sel = fwd(ex_q.d.valid && ex_q.urt, ex_q.rt, mem_q, wb_q);
    assign id_byp_rs  = hit(wb_q, id_rs);
    assign id_byp_rt  = hit(wb_q, id_rt);

    always_comb begin
        ex_d  = ex_q;
        lc_d  = lc_q;
        mem_d = ex_q.d;
        wb_d  = mem_q;   // the MEM instruction always completes
        if (mem_redirect) begin
            ex_d  = '0;
            lc_d  = 4'd0;
            mem_d = '0;
        end else if (hold) begin
            lc_d  = lc_q - 4'd1;
            mem_d = '0;
        end else if (load_use) begin
            ex_d  = '0;
        end else begin
            ex_d.d.valid = id_valid;
            ex_d.d.rw    = id_reg_write;
            ex_d.d.waddr = id_waddr;
            ex_d.load    = id_mem_read;
            ex_d.rs      = id_rs;
            ex_d.rt      = id_rt;
            ex_d.urs     = id_uses_rs;
            ex_d.urt     = id_uses_rt;
            lc_d         = (id_valid && id_long_op) ? LC_INIT : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            lc_q  <= 4'd0;
        end else if (enable) begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            lc_q  <= lc_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (enable) begin
            if (stall_pc && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (mem_redirect && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         arst_n, enable, id_valid, id_uses_rs, id_uses_rt;
    logic         id_reg_write, id_mem_read, id_long_op, mem_redirect;
    logic [W-1:0] id_rs, id_rt, id_waddr;
    logic         stall_pc, stall_ifid, bubble_idex, hold_ex, bubble_exmem, flush_ifid;
    logic [1:0]   fwd_rs_sel, fwd_rt_sel;
    logic         id_byp_rs, id_byp_rt;
`ifdef HAZARD_STATS_EN
    logic [1:0]   stall_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_ADDR_W(W), .LONG_LAT(4), .CNT_W(2)) dut (
        .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_waddr(id_waddr), .id_mem_read(id_mem_read),
        .id_long_op(id_long_op), .mem_redirect(mem_redirect),
`ifdef HAZARD_STATS_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
        .hold_ex(hold_ex), .bubble_exmem(bubble_exmem), .flush_ifid(flush_ifid),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .id_byp_rs(id_byp_rs), .id_byp_rt(id_byp_rt)
    );

    function automatic logic [11:0] outs();
        return {stall_pc, stall_ifid, bubble_idex, hold_ex, bubble_exmem, flush_ifid,
                fwd_rs_sel, fwd_rt_sel, id_byp_rs, id_byp_rt};
    endfunction

    // Drive one ID-stage instruction: valid, rs, rt, uses_rs, uses_rt, reg_write, waddr, load, long.
    task automatic set_id(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                          input logic rw, input int wa, input logic ld, input logic lg);
        id_valid = v; id_rs = W'(rs); id_rt = W'(rt); id_uses_rs = urs; id_uses_rt = urt;
        id_reg_write = rw; id_waddr = W'(wa); id_mem_read = ld; id_long_op = lg;
        #1;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Inputs are changed and outputs sampled only around the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic drain();
        nop();
        repeat (4) step();
    endtask

    task automatic test_reset();
        arst_n = 1'b0; enable = 1'b1; mem_redirect = 1'b0;
        nop();
        step();
        total++; if (outs() !== 12'd0) begin bad++; $display("FAIL reset_in got=%h exp=0", outs()); end
        arst_n = 1'b1;
        #1;
        total++; if (outs() !== 12'd0) begin bad++; $display("FAIL reset_rel got=%h exp=0", outs()); end
`ifdef HAZARD_STATS_EN
        total++; if ({stall_cnt, flush_cnt} !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", {stall_cnt, flush_cnt}); end
`endif
        step();
    endtask

    task automatic test_forward();
        set_id(1, 1, 2, 1, 1, 1, 3, 0, 0); step();               // add $3,$1,$2
        set_id(1, 3, 5, 1, 1, 1, 4, 0, 0);                        // sub $4,$3,$5
        total++; if (stall_pc !== 1'b0) begin bad++; $display("FAIL fwd_nostall got=%0d exp=0", stall_pc); end
        step();
        set_id(1, 3, 0, 1, 1, 1, 6, 0, 0);                        // or $6,$3,$0
        total++; if (fwd_rs_sel !== 2'd1) begin bad++; $display("FAIL fwd_mem_rs got=%0d exp=1", fwd_rs_sel); end
        total++; if (fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL fwd_mem_rt got=%0d exp=0", fwd_rt_sel); end
        step();
        set_id(0, 3, 7, 0, 0, 0, 0, 0, 0);                        // probe WB bypass
        total++; if (fwd_rs_sel !== 2'd2) begin bad++; $display("FAIL fwd_wb_rs got=%0d exp=2", fwd_rs_sel); end
        total++; if (fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL fwd_wb_rt0 got=%0d exp=0", fwd_rt_sel); end
        total++; if ({id_byp_rs, id_byp_rt} !== 2'b10) begin bad++; $display("FAIL id_byp got=%b exp=10", {id_byp_rs, id_byp_rt}); end
        drain();
    endtask

    task automatic test_load_use();
        set_id(1, 0, 0, 1, 0, 1, 3, 1, 0); step();               // lw $3,0($0)
        set_id(1, 3, 3, 1, 1, 1, 4, 0, 0);                        // add $4,$3,$3
        total++; if ({stall_pc, stall_ifid, bubble_idex, hold_ex} !== 4'b1110) begin
            bad++; $display("FAIL lu_stall got=%b exp=1110", {stall_pc, stall_ifid, bubble_idex, hold_ex}); end
        step();
        total++; if ({stall_pc, bubble_idex} !== 2'b00) begin bad++; $display("FAIL lu_once got=%b exp=00", {stall_pc, bubble_idex}); end
        step();
        nop();
        total++; if ({fwd_rs_sel, fwd_rt_sel} !== 4'b1010) begin
            bad++; $display("FAIL lu_fwd got=%0d/%0d exp=2/2", fwd_rs_sel, fwd_rt_sel); end
        drain();
    endtask

    task automatic test_zero_reg();
        set_id(1, 1, 2, 1, 1, 1, 0, 0, 0); step();               // add $0,$1,$2
        set_id(1, 0, 0, 1, 1, 1, 4, 0, 0); step();               // add $4,$0,$0
        nop();
        total++; if ({fwd_rs_sel, fwd_rt_sel, stall_pc} !== 5'd0) begin
            bad++; $display("FAIL zero_fwd got=%b exp=0", {fwd_rs_sel, fwd_rt_sel, stall_pc}); end
        drain();
        set_id(1, 0, 0, 1, 0, 1, 0, 1, 0); step();               // lw $0
        set_id(1, 0, 0, 1, 1, 1, 4, 0, 0);
        total++; if ({stall_pc, bubble_idex} !== 2'b00) begin bad++; $display("FAIL zero_lu got=%b exp=00", {stall_pc, bubble_idex}); end
        drain();
    endtask

    task automatic test_long_op();
        int nst = 0, nh = 0, nbx = 0;
        set_id(1, 1, 2, 1, 1, 1, 3, 0, 1); step();               // mul $3,$1,$2
        set_id(1, 3, 1, 1, 1, 1, 4, 0, 0);                        // add $4,$3,$1
        for (int i = 0; i < 10; i++) begin
            if (!stall_pc) break;
            nst++;
            if (hold_ex) nh++;
            if (bubble_exmem) nbx++;
            step();
            #1;
        end
        total++; if (nst != 3) begin bad++; $display("FAIL long_stall got=%0d exp=3", nst); end
        total++; if (nh != 3) begin bad++; $display("FAIL long_hold got=%0d exp=3", nh); end
        total++; if (nbx != 3) begin bad++; $display("FAIL long_bubex got=%0d exp=3", nbx); end
        step();
        nop();
        total++; if (fwd_rs_sel !== 2'd1) begin bad++; $display("FAIL long_fwd got=%0d exp=1", fwd_rs_sel); end
        drain();
    endtask

    task automatic test_redirect();
        set_id(1, 1, 2, 1, 1, 0, 0, 0, 0); step();               // beq
        set_id(1, 0, 0, 1, 0, 1, 3, 1, 0); step();               // lw $3 (wrong path)
        set_id(1, 3, 3, 1, 1, 1, 4, 0, 0);                        // add $4 (wrong path)
        mem_redirect = 1'b1;
        #1;
        total++; if ({flush_ifid, bubble_idex, stall_pc, stall_ifid, hold_ex} !== 5'b11000) begin
            bad++; $display("FAIL redir got=%b exp=11000", {flush_ifid, bubble_idex, stall_pc, stall_ifid, hold_ex}); end
        step();
        mem_redirect = 1'b0;
        // Third wrong-path instr arrives flushed; probe WB for $3/$4/$5 writes.
        set_id(0, 3, 4, 0, 0, 1, 5, 0, 0);
        for (int i = 0; i < 4; i++) begin
            id_rs = (i == 3) ? W'(5) : W'(3);
            #1;
            total++; if ({id_byp_rs, id_byp_rt, stall_pc} !== 3'b000) begin
                bad++; $display("FAIL redir_wb%0d got=%b exp=000", i, {id_byp_rs, id_byp_rt, stall_pc}); end
            step();
        end
        drain();
    endtask

    task automatic test_redirect_hold();
        set_id(1, 1, 2, 1, 1, 1, 5, 0, 1); step();               // mul $5
        nop();
        total++; if (hold_ex !== 1'b1) begin bad++; $display("FAIL rh_pre got=%0d exp=1", hold_ex); end
        mem_redirect = 1'b1;
        #1;
        total++; if ({hold_ex, stall_pc, flush_ifid} !== 3'b001) begin
            bad++; $display("FAIL rh_ovr got=%b exp=001", {hold_ex, stall_pc, flush_ifid}); end
        step();
        mem_redirect = 1'b0;
        #1;
        total++; if ({hold_ex, stall_pc} !== 2'b00) begin bad++; $display("FAIL rh_clr got=%b exp=00", {hold_ex, stall_pc}); end
        drain();
    endtask

    task automatic test_enable_freeze();
        set_id(1, 0, 0, 1, 0, 1, 3, 1, 0); step();               // lw $3
        set_id(1, 3, 0, 1, 0, 1, 4, 0, 0);                        // add $4,$3
        enable = 1'b0;
        step(); step();
        #1;
        total++; if (stall_pc !== 1'b1) begin bad++; $display("FAIL frz_hold got=%0d exp=1", stall_pc); end
        enable = 1'b1;
        step();
        #1;
        total++; if (stall_pc !== 1'b0) begin bad++; $display("FAIL frz_rel got=%0d exp=0", stall_pc); end
        step();
        nop();
        total++; if (fwd_rs_sel !== 2'd2) begin bad++; $display("FAIL frz_fwd got=%0d exp=2", fwd_rs_sel); end
        drain();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        arst_n = 1'b0; #2; arst_n = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            set_id(1, 0, 0, 1, 0, 1, 3, 1, 0); step();
            set_id(1, 3, 3, 1, 1, 1, 4, 0, 0); step();
            drain();
        end
        total++; if (stall_cnt !== 2'd3) begin bad++; $display("FAIL stall_sat got=%0d exp=3", stall_cnt); end
        total++; if (flush_cnt !== 2'd0) begin bad++; $display("FAIL flush_pre got=%0d exp=0", flush_cnt); end
        mem_redirect = 1'b1; step(); mem_redirect = 1'b0;
        #1;
        total++; if (flush_cnt !== 2'd1) begin bad++; $display("FAIL flush_one got=%0d exp=1", flush_cnt); end
        drain();
    endtask
`endif

    task automatic test_reset_mid_hold();
        set_id(1, 1, 2, 1, 1, 1, 3, 0, 1); step();               // mul $3
        nop();
        total++; if (hold_ex !== 1'b1) begin bad++; $display("FAIL rmh_pre got=%0d exp=1", hold_ex); end
        arst_n = 1'b0;
        #1;
        total++; if (outs() !== 12'd0) begin bad++; $display("FAIL rmh_async got=%h exp=0", outs()); end
        step();
        arst_n = 1'b1;
        step();
        #1;
        total++; if (outs() !== 12'd0) begin bad++; $display("FAIL rmh_after got=%h exp=0", outs()); end
`ifdef HAZARD_STATS_EN
        total++; if ({stall_cnt, flush_cnt} !== 4'd0) begin bad++; $display("FAIL rmh_cnt got=%h exp=0", {stall_cnt, flush_cnt}); end
`endif
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_zero_reg();
        test_long_op();
        test_redirect();
        test_redirect_hold();
        test_enable_freeze();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
